// File: rtl/rede_float_feeder_if.sv
// Purpose: sample feeder bus; carries upstream push handshake, network request/present and status.
// Latency: n/a (signal bundle only).
// Backpressure: s_ready from the feeder throttles s_valid; req_in from the network paces in_data.
// Ports (master = producer/network side, slave = feeder):
//   flush, s_valid, s_data, req_in        -> into the feeder
//   s_ready, in_data, in_valid, level, underflow <- out of the feeder
interface rede_float_feeder_if #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic [3:0]        req_in;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [LVL_W-1:0]  level;
  logic              underflow;

  modport master (
    output flush, s_valid, s_data, req_in,
    input  s_ready, in_data, in_valid, level, underflow
  );

  modport slave (
    input  flush, s_valid, s_data, req_in,
    output s_ready, in_data, in_valid, level, underflow
  );
endinterface

// File: rtl/rede_float_feeder.sv
// Purpose: FIFO feeder presenting the oldest buffered sample show-ahead to rede_float, gated by a prefill threshold.
// Latency: a push into an empty feeder appears on in_data on the accepting edge; a pop exposes the next sample on the same edge.
// Backpressure: s_ready drops when DEPTH samples are held or during flush; upstream must hold s_valid/s_data.
// Ports: clk, rst (async active-low), bus (rede_float_feeder_if.slave):
//   flush / s_valid / s_data / s_ready push side, req_in / in_data / in_valid network side,
//   level (held samples incl. the one on in_data), underflow (sticky request-on-empty).
module rede_float_feeder #(
  parameter int         DATA_W   = 19,
  parameter int         DEPTH    = 16,
  parameter int         PREFILL  = 4,
  parameter logic [3:0] REQ_CODE = 4'd1
) (
  input  logic               clk,
  input  logic               rst,
  rede_float_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_q, level_nx;
  logic [DATA_W-1:0] data_q, data_nx;
  logic              valid_q;
  logic              uf_q;

  logic push, pop_req, pop, uf_hit;

  assign bus.s_ready = (level_q < LW'(DEPTH)) && !bus.flush;

  assign push    = bus.s_valid && bus.s_ready;
  assign pop_req = (bus.req_in == REQ_CODE);
  assign pop     = pop_req && (state == ST_RUN) && (level_q != '0);
  assign uf_hit  = pop_req && (state == ST_RUN) && (level_q == '0);

  always_comb begin
    level_nx = level_q;
    if (push && !pop)
      level_nx = level_q + LW'(1);
    else if (pop && !push)
      level_nx = level_q - LW'(1);
  end

  // Requests are never honoured in FILL, so the level there only grows.
  always_comb begin
    state_nx = state;
    if (state == ST_FILL && level_nx >= LW'(PREFILL))
      state_nx = ST_RUN;
  end

  // in_data is a registered copy of the head entry. The head also stays in
  // mem, so after a pop the next-oldest sample is mem[rd_ptr+1] when one is
  // already stored; with a single entry left the only candidate is the
  // sample being pushed on this very edge.
  always_comb begin
    data_nx = data_q;
    if (pop) begin
      if (level_q >= LW'(2))
        data_nx = mem[rd_ptr + AW'(1)];
      else if (push)
        data_nx = bus.s_data;
    end else if (push && level_q == '0) begin
      data_nx = bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= bus.s_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else if (bus.flush) begin
      state   <= ST_FILL;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      level_q <= level_nx;
      data_q  <= data_nx;
      valid_q <= (state_nx == ST_RUN) && (level_nx != '0);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (uf_hit)
        uf_q <= 1'b1;
    end
  end

  assign bus.in_data   = data_q;
  assign bus.in_valid  = valid_q;
  assign bus.level     = level_q;
  assign bus.underflow = uf_q;
endmodule

// File: tb/tb_rede_float_feeder.sv
// Purpose: self-checking bench for rede_float_feeder against a queue-based reference model.
// Latency: outputs compared 1 ns after each rising edge, s_ready 1 ns after inputs change.
// Backpressure: model decides acceptance from its own occupancy, never from the DUT.
module tb_rede_float_feeder;
  localparam int DATA_W  = 19;
  localparam int DEPTH   = 16;
  localparam int PREFILL = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rede_float_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  rede_float_feeder #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .PREFILL(PREFILL), .REQ_CODE(4'd1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: a plain queue of held samples plus run/underflow flags.
  logic [DATA_W-1:0] q[$];
  bit                m_run;
  bit                m_uf;
  logic [DATA_W-1:0] m_data;

  task automatic model_clear();
    q.delete();
    m_run  = 1'b0;
    m_uf   = 1'b0;
    m_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic vld, input logic [DATA_W-1:0] d,
                            input logic [3:0] req, input logic fl, input logic rdy);
    if (fl) begin
      model_clear();
    end else begin
      if (req == 4'd1 && m_run) begin
        if (q.size() > 0) void'(q.pop_front());
        else m_uf = 1'b1;
      end
      if (vld && rdy) q.push_back(d);
      if (!m_run && q.size() >= PREFILL) m_run = 1'b1;
      if (q.size() > 0) m_data = q[0];
    end
  endtask

  task automatic check_outputs();
    chk("level", 32'(bus.level), 32'(q.size()));
    chk("in_valid", 32'(bus.in_valid), 32'(m_run && q.size() > 0));
    chk("in_data", 32'(bus.in_data), 32'(m_data));
    chk("underflow", 32'(bus.underflow), 32'(m_uf));
  endtask

  // One clock of stimulus, entered and left 1 ns after a rising edge.
  task automatic step(input logic vld, input logic [DATA_W-1:0] d,
                      input logic [3:0] req, input logic fl);
    logic exp_rdy;
    bus.s_valid = vld;
    bus.s_data  = d;
    bus.req_in  = req;
    bus.flush   = fl;
    #1;
    exp_rdy = (q.size() < DEPTH) && !fl;
    chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
    model_edge(vld, d, req, fl, exp_rdy);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int r;
    logic [3:0] rq;
    bus.flush   = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 19'h12345;
    bus.req_in  = 4'd1;
    model_clear();

    // Reset held for three edges with a live upstream sample.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_in_valid", 32'(bus.in_valid), 32'd0);
      chk("rst_in_data", 32'(bus.in_data), 32'd0);
      chk("rst_underflow", 32'(bus.underflow), 32'd0);
    end
    bus.s_valid = 1'b0;
    bus.req_in  = 4'd0;
    rst = 1'b1;
    #1;
    chk("rst_s_ready", 32'(bus.s_ready), 32'd1);

    // Prefill: requests ignored until PREFILL samples held.
    step(1'b1, 19'd3, 4'd1, 1'b0);
    step(1'b1, 19'(-5), 4'd1, 1'b0);
    step(1'b1, 19'd7, 4'd1, 1'b0);
    chk("prefill_level3", 32'(bus.level), 32'd3);
    chk("prefill_invalid", 32'(bus.in_valid), 32'd0);
    step(1'b1, 19'd100, 4'd1, 1'b0);
    chk("prefill_level4", 32'(bus.level), 32'd4);
    chk("prefill_valid", 32'(bus.in_valid), 32'd1);
    chk("prefill_head", 32'(bus.in_data), 32'd3);

    // Non-matching codes never pop; then an ordered drain.
    step(1'b0, '0, 4'd2, 1'b0);
    step(1'b0, '0, 4'd0, 1'b0);
    step(1'b0, '0, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 4'd1, 1'b0);
    chk("drain_level0", 32'(bus.level), 32'd0);
    chk("drain_hold", 32'(bus.in_data), 32'd100);

    // Underflow in RUN, then extremes pass through unchanged.
    step(1'b0, '0, 4'd1, 1'b0);
    chk("uf_set", 32'(bus.underflow), 32'd1);
    chk("uf_hold", 32'(bus.in_data), 32'd100);
    step(1'b1, 19'h40000, 4'd0, 1'b0);
    chk("uf_min_head", 32'(bus.in_data), 32'h40000);
    step(1'b1, 19'h3FFFF, 4'd0, 1'b0);
    step(1'b0, '0, 4'd1, 1'b0);
    chk("uf_max_head", 32'(bus.in_data), 32'h3FFFF);
    step(1'b0, '0, 4'd1, 1'b0);
    chk("uf_sticky", 32'(bus.underflow), 32'd1);

    // Flush, then fill to full with 0..15 and probe the full boundary.
    step(1'b0, '0, 4'd0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 19'(i), 4'd0, 1'b0);
    step(1'b1, 19'd16, 4'd0, 1'b0);          // refused: full
    chk("full_level", 32'(bus.level), 32'd16);
    step(1'b1, 19'd16, 4'd1, 1'b0);          // pop only
    chk("full_pop_only", 32'(bus.level), 32'd15);
    chk("full_head1", 32'(bus.in_data), 32'd1);
    for (int i = 17; i < 21; i++) step(1'b1, 19'(i), 4'd1, 1'b0);
    chk("simul_level", 32'(bus.level), 32'd15);
    chk("simul_head", 32'(bus.in_data), 32'd5);

    // Drain to 6 then flush alongside push+pop.
    for (int i = 0; i < 9; i++) step(1'b0, '0, 4'd1, 1'b0);
    chk("pre_flush_level", 32'(bus.level), 32'd6);
    step(1'b1, 19'd99, 4'd1, 1'b1);
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_data", 32'(bus.in_data), 32'd0);

    // Level-1 push+pop handoff straight to in_data.
    for (int i = 0; i < PREFILL; i++) step(1'b1, 19'(200 + i), 4'd0, 1'b0);
    for (int i = 0; i < PREFILL - 1; i++) step(1'b0, '0, 4'd1, 1'b0);
    step(1'b1, 19'd777, 4'd1, 1'b0);
    chk("handoff", 32'(bus.in_data), 32'd777);

    // Randomized traffic with phases biased towards filling and draining.
    for (int i = 0; i < 600; i++) begin
      r  = $urandom_range(0, 7);
      rq = (r < 4) ? 4'd1 : 4'(r);
      if ((i / 60) % 2 == 0)
        step($urandom_range(0, 3) != 0, DATA_W'($urandom), ($urandom_range(0, 2) == 0) ? rq : 4'd0,
             $urandom_range(0, 99) == 0);
      else
        step($urandom_range(0, 3) == 0, DATA_W'($urandom), rq, $urandom_range(0, 99) == 0);
    end

    // Async reset mid-drain, between clock edges.
    step(1'b0, '0, 4'd0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 19'(300 + i), 4'd0, 1'b0);
    step(1'b0, '0, 4'd1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_level", 32'(bus.level), 32'd0);
    chk("arst_in_valid", 32'(bus.in_valid), 32'd0);
    chk("arst_in_data", 32'(bus.in_data), 32'd0);
    chk("arst_underflow", 32'(bus.underflow), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 19'd55, 4'd1, 1'b0);
    chk("post_arst_head", 32'(bus.in_data), 32'd55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
